// File: rtl/param_rr_channel_mux_if.sv
// Handshake bundle for param_rr_channel_mux: NCH producer channels in,
// one registered item (data + channel ID) out.
interface param_rr_channel_mux_if #(
  parameter int NCH = 8,
  parameter int W   = 4
);
  localparam int IDW = $clog2(NCH);

  logic             mode;
  logic [IDW-1:0]   sel;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic [W-1:0]     out_data;
  logic [IDW-1:0]   out_id;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_id, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_id, out_valid
  );
endinterface

// File: rtl/param_rr_channel_mux.sv
// Registered N-channel selector: direct index select or round-robin scan,
// with valid/ready on every input channel and on the single output.
module param_rr_channel_mux #(
  parameter int NCH = 8,
  parameter int W   = 4
) (
  input logic                  clock,
  input logic                  reset,
  param_rr_channel_mux_if.slave bus
);
  localparam int IDW = $clog2(NCH);

  logic [W-1:0]   out_data_reg;
  logic [IDW-1:0] out_id_reg;
  logic           out_valid_reg;
  logic [IDW-1:0] ptr_reg;

  logic           sel_ok;
  logic           found;
  logic [IDW-1:0] cand;
  logic [W-1:0]   cand_data;
  logic [IDW-1:0] ptr_next;
  logic           load;
  logic           grant;

  // With a non-power-of-2 channel count some sel codes address nothing.
  generate
    if (NCH == (1 << IDW)) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_part
      assign sel_ok = ({1'b0, bus.sel} < (IDW+1)'(NCH));
    end
  endgenerate

  always_comb begin : cand_search
    int s;
    logic [IDW-1:0] idx;
    found = 1'b0;
    cand  = '0;
    s     = 0;
    idx   = '0;
    if (!bus.mode) begin
      cand  = bus.sel;
      found = sel_ok && bus.in_valid[bus.sel];
    end else begin
      for (int k = 0; k < NCH; k++) begin
        s = int'(ptr_reg) + k;
        if (s >= NCH) s = s - NCH;
        idx = IDW'(s);
        if (!found && bus.in_valid[idx]) begin
          found = 1'b1;
          cand  = idx;
        end
      end
    end
  end

  always_comb begin
    cand_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cand == IDW'(k)) cand_data = bus.in_data[k*W +: W];
    end
  end

  assign load     = !out_valid_reg || bus.out_ready;
  assign grant    = load && found && !reset;
  assign ptr_next = (cand == IDW'(NCH-1)) ? '0 : cand + 1'b1;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign bus.in_ready[gi] = grant && (cand == IDW'(gi));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
      ptr_reg       <= '0;
    end else if (load) begin
      if (found) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= cand_data;
        out_id_reg    <= cand;
        ptr_reg       <= ptr_next;
      end else begin
        // Nothing to take: drop valid, keep last data/id visible.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_id    = out_id_reg;
  assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_param_rr_channel_mux.sv
// Bench for param_rr_channel_mux: vector table, hand-written corner sequences
// and random traffic compared against a behavioural model.
module tb_param_rr_channel_mux;
  localparam int NCH = 8;
  localparam int W   = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  param_rr_channel_mux_if #(.NCH(NCH), .W(W)) bus ();

  param_rr_channel_mux #(.NCH(NCH), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit         mode;
    logic [2:0] sel;
    logic [7:0] valid;
    bit         ordy;
    logic [7:0] exp_ready;
    bit         exp_valid;
    logic [2:0] exp_id;
    logic [3:0] exp_data;
  } vec_t;

  vec_t vecs[15];

  int checks = 0;
  int errors = 0;

  bit         m_valid;
  logic [3:0] m_data;
  logic [2:0] m_id;
  int         m_ptr;
  logic [7:0] ready_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Candidate straight from the selection rules.
  task automatic model_cand(output bit ok, output int c);
    ok = 1'b0;
    c  = 0;
    if (!bus.mode) begin
      c  = int'(bus.sel);
      ok = (c < NCH) && bus.in_valid[bus.sel];
    end else begin
      for (int k = 0; k < NCH; k++) begin
        int j;
        j = (m_ptr + k) % NCH;
        if (!ok && ((bus.in_valid >> j) & 8'h01) != 8'h00) begin
          ok = 1'b1;
          c  = j;
        end
      end
    end
  endtask

  // Called at a negedge with inputs applied; returns at the next negedge.
  task automatic tick();
    bit         ok;
    int         c;
    bit         load;
    logic [7:0] er;
    #1;
    model_cand(ok, c);
    load = !m_valid || bus.out_ready;
    er = 8'h00;
    if (!reset && load && ok) er = 8'h01 << c;
    ready_seen = bus.in_ready;
    check("in_ready", {24'h0, ready_seen}, {24'h0, er});
    @(posedge clock);
    if (reset) begin
      m_valid = 1'b0;
      m_data  = 4'h0;
      m_id    = 3'h0;
      m_ptr   = 0;
    end else if (load) begin
      if (ok) begin
        m_valid = 1'b1;
        m_data  = 4'(bus.in_data >> (c*W));
        m_id    = 3'(c);
        m_ptr   = (c + 1) % NCH;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("out_valid", {31'h0, bus.out_valid}, {31'h0, m_valid});
    check("out_id",    {29'h0, bus.out_id},    {29'h0, m_id});
    check("out_data",  {28'h0, bus.out_data},  {28'h0, m_data});
    @(negedge clock);
  endtask

  task automatic drive(input bit md, input logic [2:0] s, input logic [7:0] v, input bit r);
    bus.mode      = md;
    bus.sel       = s;
    bus.in_valid  = v;
    bus.out_ready = r;
  endtask

  initial begin
    m_valid = 1'b0; m_data = 4'h0; m_id = 3'h0; m_ptr = 0;
    for (int k = 0; k < NCH; k++) bus.in_data[k*W +: W] = 4'(k + 3);
    reset = 1'b1;
    drive(1'b1, 3'd0, 8'hFF, 1'b1);

    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b0, 3'(i), 8'hFF, 1'b1, 8'h01 << i, 1'b1, 3'(i), 4'(i + 3)};
    vecs[8]  = '{1'b1, 3'd0, 8'h85, 1'b1, 8'h01, 1'b1, 3'd0, 4'd3};
    vecs[9]  = '{1'b1, 3'd0, 8'h85, 1'b1, 8'h04, 1'b1, 3'd2, 4'd5};
    vecs[10] = '{1'b1, 3'd0, 8'h85, 1'b1, 8'h80, 1'b1, 3'd7, 4'd10};
    vecs[11] = '{1'b1, 3'd0, 8'h85, 1'b1, 8'h01, 1'b1, 3'd0, 4'd3};
    vecs[12] = '{1'b1, 3'd0, 8'h85, 1'b1, 8'h04, 1'b1, 3'd2, 4'd5};
    vecs[13] = '{1'b1, 3'd0, 8'h85, 1'b1, 8'h80, 1'b1, 3'd7, 4'd10};
    vecs[14] = '{1'b0, 3'd3, 8'hF7, 1'b1, 8'h00, 1'b0, 3'd7, 4'd10};

    @(negedge clock);
    tick();
    tick();
    check("rst_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_id",    {29'h0, bus.out_id},    32'h0);
    check("rst_data",  {28'h0, bus.out_data},  32'h0);
    reset = 1'b0;
    tick();
    check("first_ready", {24'h0, ready_seen}, 32'h01);
    check("first_id",    {29'h0, bus.out_id}, 32'h0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].ordy);
      tick();
      check("vec_ready", {24'h0, ready_seen},    {24'h0, vecs[i].exp_ready});
      check("vec_valid", {31'h0, bus.out_valid}, {31'h0, vecs[i].exp_valid});
      check("vec_id",    {29'h0, bus.out_id},    {29'h0, vecs[i].exp_id});
      check("vec_data",  {28'h0, bus.out_data},  {28'h0, vecs[i].exp_data});
    end

    // Backpressure holds the item and blocks every channel.
    drive(1'b1, 3'd0, 8'hFF, 1'b1);
    tick();
    check("bp_first_id", {29'h0, bus.out_id}, 32'h0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready", {24'h0, ready_seen}, 32'h0);
      check("bp_id",    {29'h0, bus.out_id}, 32'h0);
      check("bp_valid", {31'h0, bus.out_valid}, 32'h1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_rel_id1", {29'h0, bus.out_id}, 32'h1);
    tick();
    check("bp_rel_id2", {29'h0, bus.out_id}, 32'h2);

    // Empty input and a one-cycle valid pulse.
    bus.in_valid = 8'h00;
    tick();
    check("empty_valid", {31'h0, bus.out_valid}, 32'h0);
    bus.in_valid = 8'h20;
    tick();
    check("pulse_valid", {31'h0, bus.out_valid}, 32'h1);
    check("pulse_id",    {29'h0, bus.out_id},    32'h5);
    bus.in_valid = 8'h00;
    tick();
    check("pulse_gone", {31'h0, bus.out_valid}, 32'h0);

    // Reset while stalled must discard the item and rewind the pointer.
    bus.in_valid = 8'h10;
    tick();
    check("mid_id4", {29'h0, bus.out_id}, 32'h4);
    bus.out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    check("mid_rst_id",    {29'h0, bus.out_id},    32'h0);
    reset = 1'b0;
    drive(1'b1, 3'd0, 8'h48, 1'b1);
    tick();
    check("mid_ready", {24'h0, ready_seen}, 32'h08);
    check("mid_id3",   {29'h0, bus.out_id}, 32'h3);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      bus.in_data = 32'($urandom);
      drive(1'($urandom), 3'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 3) == 0) bus.in_valid = 8'hFF;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
